// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder: 1-cycle fetch port plus 32-bit line loader
// Optional IMEM_RDCNT_EN adds a saturating fetch counter output (rdcnt).
module imem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   raddr,
  input  logic          rceb,
  output logic [255:0]  q,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_line,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          busy
`ifdef IMEM_RDCNT_EN
  ,
  output logic [31:0]   rdcnt
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t         state;
  logic [2:0]     beat;
  logic [255:0]   line_buf;
  logic [AW-1:0]  line_idx;
  logic [255:0]   mem [DEPTH];

  logic [AW-1:0]  rd_idx;
  logic           rd_ok;
  logic           wr_ok;
  logic           unused_raddr;

  assign rd_idx       = raddr[AW:1];
  assign rd_ok        = {1'b0, rd_idx} < DEPTH_L;
  assign wr_ok        = {1'b0, line_idx} < DEPTH_L;
  assign unused_raddr = ^{raddr[15:AW+1], raddr[0]};

  // Fetch port: the memory write below lands on the same edge, so a
  // collision on the committing line returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!rceb && rd_ok) begin
      q <= mem[rd_idx];
    end else begin
      q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == COMMIT && wr_ok) begin
      mem[line_idx] <= line_buf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= 3'd0;
      line_buf <= '0;
      line_idx <= '0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            line_idx <= ld_line;
            beat     <= 3'd0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= FILL;
          end
        end
        FILL: begin
          if (ld_valid && ld_ready) begin
            line_buf[{beat, 5'b0} +: 32] <= ld_data;
            beat <= beat + 3'd1;
            if (beat == 3'd7) begin
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
              state    <= COMMIT;
            end
          end
        end
        COMMIT: begin
          ld_done <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ld_ready <= 1'b0;
          ld_done  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_RDCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rdcnt <= '0;
    end else if (!rceb && rdcnt != 32'hFFFF_FFFF) begin
      rdcnt <= rdcnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed table-driven bench for imem_responder
// Exercises the IMEM_RDCNT_EN counter when that macro is defined.
module tb_imem_responder;

  logic         clk;
  logic         rst;
  logic [15:0]  raddr;
  logic         rceb;
  logic [255:0] q;
  logic         ld_start;
  logic [9:0]   ld_line;
  logic         ld_valid;
  logic [31:0]  ld_data;
  logic         ld_ready;
  logic         ld_done;
  logic         busy;
`ifdef IMEM_RDCNT_EN
  logic [31:0]  rdcnt;
`endif

  imem_responder #(.DEPTH(1024), .AW(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr),
    .rceb     (rceb),
    .q        (q),
    .ld_start (ld_start),
    .ld_line  (ld_line),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .busy     (busy)
`ifdef IMEM_RDCNT_EN
    ,
    .rdcnt    (rdcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (ld_done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         rceb;
    logic [15:0]  raddr;
    logic [255:0] exp_q;
  } vec_t;

  vec_t vecs[10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [9:0] line, input logic [255:0] data, input logic [23:0] gaps);
    int d0;
    d0 = done_cnt;
    ld_start = 1'b1; ld_line = line; ld_valid = 1'b0;
    tick;
    ld_start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_ready", ld_ready, 1);
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < int'(gaps[3*k +: 3]); g++) begin
        ld_valid = 1'b0; ld_start = 1'b1; ld_line = line + 10'd1;
        tick;
        ld_start = 1'b0;
        chk("gap_busy", busy, 1);
        chk("gap_ready", ld_ready, 1);
        chk("gap_done", ld_done, 0);
      end
      ld_valid = 1'b1; ld_data = data[32*k +: 32];
      tick;
    end
    ld_valid = 1'b0;
    chk("commit_done", ld_done, 1);
    chk("commit_ready", ld_ready, 0);
    chk("commit_busy", busy, 1);
    tick;
    chk("post_done", ld_done, 0);
    chk("post_busy", busy, 0);
    chk("done_once", 256'(done_cnt - d0), 1);
  endtask

  logic [255:0] l3, p7, d9, ab, as_line, fives;
  logic [13:0]  rd_pat;
  int           d_before;

  initial begin
    for (int k = 0; k < 8; k++) begin
      l3[32*k +: 32] = 32'(k + 1);
      p7[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
      d9[32*k +: 32] = 32'h9000_0000 ^ (32'(k) * 32'h1111);
      ab[32*k +: 32] = 32'hDEAD_0000 + 32'(k);
    end
    as_line = {64{4'hA}};
    fives   = {64{4'h5}};

    vecs[0] = '{1'b0, 16'h0006, l3};
    vecs[1] = '{1'b0, 16'h0007, l3};
    vecs[2] = '{1'b1, 16'h0006, 256'd0};
    vecs[3] = '{1'b0, 16'h0008, l3};
    vecs[4] = '{1'b0, 16'h000A, fives};
    vecs[5] = '{1'b0, 16'h000E, p7};
    vecs[6] = '{1'b1, 16'h000E, 256'd0};
    vecs[7] = '{1'b0, 16'h0012, d9};
    vecs[8] = '{1'b0, 16'h8006, l3};
    vecs[9] = '{1'b0, 16'hF80E, p7};

    rst = 1'b1; rceb = 1'b1; raddr = 16'h0; ld_start = 1'b0; ld_line = 10'd0;
    ld_valid = 1'b0; ld_data = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_q", q, 0);
      chk("rst_ready", ld_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", ld_done, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("idle_q", q, 0);
    end

    ld_valid = 1'b1; ld_data = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("idle_valid_busy", busy, 0);
      chk("idle_valid_ready", ld_ready, 0);
    end
    ld_valid = 1'b0;

    do_load(10'd3, l3, 24'd0);
    rceb = 1'b0; raddr = 16'h0006;
    tick;
    rceb = 1'b1;
    chk("fetch_line3", q, l3);

    do_load(10'd4, l3, {3'd1, 3'd0, 3'd3, 3'd1, 3'd0, 3'd3, 3'd1, 3'd0});

    do_load(10'd5, as_line, 24'd0);
    rceb = 1'b0; raddr = 16'h000A;
    tick;
    chk("coll_pre", q, as_line);
    do_load(10'd5, fives, 24'd0);
    chk("coll_commit_old", q, as_line);
    tick;
    chk("coll_next_new", q, fives);
    rceb = 1'b1;

    do_load(10'd7, p7, 24'd0);
    d_before = done_cnt;
    ld_start = 1'b1; ld_line = 10'd7;
    tick;
    ld_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ld_valid = 1'b1; ld_data = ab[32*k +: 32];
      tick;
    end
    ld_valid = 1'b0; rst = 1'b1; rceb = 1'b0; raddr = 16'h0006;
    tick;
    chk("mid_rst_q", q, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ld_ready, 0);
    chk("mid_rst_done", ld_done, 0);
    rst = 1'b0; rceb = 1'b1;
    chk("mid_rst_no_done", 256'(done_cnt - d_before), 0);
    do_load(10'd9, d9, 24'd0);

    for (int i = 0; i < 10; i++) begin
      rceb = vecs[i].rceb; raddr = vecs[i].raddr;
      tick;
      chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
    end
    rceb = 1'b1;
    tick;
    chk("final_idle_q", q, 0);

`ifdef IMEM_RDCNT_EN
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rdcnt_rst", rdcnt, 0);
    rd_pat = 14'b11011101101110;
    raddr = 16'h0006;
    for (int i = 0; i < 14; i++) begin
      rceb = ~rd_pat[i];
      tick;
    end
    rceb = 1'b1;
    tick;
    chk("rdcnt_ten", rdcnt, 10);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rdcnt_clear", rdcnt, 0);
`else
    rd_pat = 14'd0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
